// File: rtl/decode_pkg.sv
// Shared constants for the MIPS decode stage: opcode/funct encodings,
// ALU operation codes and the control-bit bundle with its bubble value.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;

    // Immediate formatting selected by the decoder.
    localparam logic [1:0] IMM_SEXT  = 2'd0;
    localparam logic [1:0] IMM_ZEXT  = 2'd1;
    localparam logic [1:0] IMM_LUI   = 2'd2;
    localparam logic [1:0] IMM_SHAMT = 2'd3;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       branch_ne;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/decode_stage_control_decoder.sv
// Combinational opcode/funct decoder: control bits, destination and
// immediate format selection, rt-usage for hazard checks, illegal flag.
module control_decoder
    import decode_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_op,
    output logic       o_alu_src,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic       o_mem_to_reg,
    output logic       o_branch,
    output logic       o_branch_ne,
    output logic       o_dst_rd,
    output logic       o_uses_rt,
    output logic [1:0] o_imm_sel,
    output logic       o_illegal
);

    ctrl_t ctrl;

    always_comb begin
        ctrl      = CTRL_NOP;
        o_dst_rd  = 1'b0;
        o_uses_rt = 1'b0;
        o_imm_sel = IMM_SEXT;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_dst_rd       = 1'b1;
                o_uses_rt      = 1'b1;
                ctrl.reg_write = 1'b1;
                case (i_funct)
                    FN_ADD: ctrl.alu_op = ALU_ADD;
                    FN_SUB: ctrl.alu_op = ALU_SUB;
                    FN_AND: ctrl.alu_op = ALU_AND;
                    FN_OR:  ctrl.alu_op = ALU_OR;
                    FN_XOR: ctrl.alu_op = ALU_XOR;
                    FN_NOR: ctrl.alu_op = ALU_NOR;
                    FN_SLT: ctrl.alu_op = ALU_SLT;
                    FN_SLL: begin ctrl.alu_op = ALU_SLL; o_imm_sel = IMM_SHAMT; end
                    FN_SRL: begin ctrl.alu_op = ALU_SRL; o_imm_sel = IMM_SHAMT; end
                    FN_SRA: begin ctrl.alu_op = ALU_SRA; o_imm_sel = IMM_SHAMT; end
                    default: begin
                        ctrl      = CTRL_NOP;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin ctrl.alu_op = ALU_ADD; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_SLTI: begin ctrl.alu_op = ALU_SLT; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_ANDI: begin
                ctrl.alu_op = ALU_AND; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                o_imm_sel   = IMM_ZEXT;
            end
            OP_ORI: begin
                ctrl.alu_op = ALU_OR; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                o_imm_sel   = IMM_ZEXT;
            end
            OP_XORI: begin
                ctrl.alu_op = ALU_XOR; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                o_imm_sel   = IMM_ZEXT;
            end
            OP_LUI: begin
                ctrl.alu_op = ALU_LUI; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                o_imm_sel   = IMM_LUI;
            end
            OP_LW: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                o_uses_rt      = 1'b1;
            end
            OP_BEQ: begin ctrl.alu_op = ALU_SUB; ctrl.branch = 1'b1;    o_uses_rt = 1'b1; end
            OP_BNE: begin ctrl.alu_op = ALU_SUB; ctrl.branch_ne = 1'b1; o_uses_rt = 1'b1; end
            default: o_illegal = 1'b1;
        endcase
    end

    assign o_alu_op     = ctrl.alu_op;
    assign o_alu_src    = ctrl.alu_src;
    assign o_mem_read   = ctrl.mem_read;
    assign o_mem_write  = ctrl.mem_write;
    assign o_reg_write  = ctrl.reg_write;
    assign o_mem_to_reg = ctrl.mem_to_reg;
    assign o_branch     = ctrl.branch;
    assign o_branch_ne  = ctrl.branch_ne;

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: field split, register-bank read ports,
// write-back bypass, load-use hazard detection and the ID/EX register.
module decode_stage
    import decode_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDRESS = 5,
    parameter int NB_INSTR   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic [NB_INSTR-1:0]   i_instr,
    input  logic [NB_DATA-1:0]    i_pc,
    input  logic                  i_flush,
    input  logic                  i_wb_en,
    input  logic [NB_ADDRESS-1:0] i_wb_addr,
    input  logic [NB_DATA-1:0]    i_wb_data,
    output logic [NB_ADDRESS-1:0] o_r1_addr,
    output logic [NB_ADDRESS-1:0] o_r2_addr,
    output logic                  o_r1_en,
    output logic                  o_r2_en,
    input  logic [NB_DATA-1:0]    i_r1_data,
    input  logic [NB_DATA-1:0]    i_r2_data,
    output logic                  o_stall,
    output logic                  o_illegal,
    output logic                  o_ex_valid,
    output logic [NB_DATA-1:0]    o_ex_pc,
    output logic [NB_DATA-1:0]    o_ex_rs_data,
    output logic [NB_DATA-1:0]    o_ex_rt_data,
    output logic [NB_DATA-1:0]    o_ex_imm,
    output logic [NB_ADDRESS-1:0] o_ex_rs,
    output logic [NB_ADDRESS-1:0] o_ex_rt,
    output logic [NB_ADDRESS-1:0] o_ex_rd,
    output logic [3:0]            o_ex_alu_op,
    output logic                  o_ex_alu_src,
    output logic                  o_ex_mem_read,
    output logic                  o_ex_mem_write,
    output logic                  o_ex_reg_write,
    output logic                  o_ex_mem_to_reg,
    output logic                  o_ex_branch,
    output logic                  o_ex_branch_ne
);

    typedef struct packed {
        logic                  valid;
        logic [NB_DATA-1:0]    pc;
        logic [NB_DATA-1:0]    rs_data;
        logic [NB_DATA-1:0]    rt_data;
        logic [NB_DATA-1:0]    imm;
        logic [NB_ADDRESS-1:0] rs;
        logic [NB_ADDRESS-1:0] rt;
        logic [NB_ADDRESS-1:0] rd;
        ctrl_t                 ctrl;
    } idex_t;

    idex_t idex_q, idex_d, dec;
    logic  illegal_q, illegal_d;

    logic [5:0]            opcode, funct;
    logic [NB_ADDRESS-1:0] rs, rt, rd, dest;
    logic [4:0]            shamt;
    logic [15:0]           imm16;

    assign opcode = i_instr[31:26];
    assign rs     = i_instr[25:21];
    assign rt     = i_instr[20:16];
    assign rd     = i_instr[15:11];
    assign shamt  = i_instr[10:6];
    assign funct  = i_instr[5:0];
    assign imm16  = i_instr[15:0];

    assign o_r1_addr = rs;
    assign o_r2_addr = rt;
    assign o_r1_en   = i_valid;
    assign o_r2_en   = i_valid;

    ctrl_t      dec_ctrl;
    logic [3:0] dec_alu_op;
    logic       dec_alu_src, dec_mem_read, dec_mem_write, dec_reg_write;
    logic       dec_mem_to_reg, dec_branch, dec_branch_ne;
    logic       dec_dst_rd, dec_uses_rt, dec_illegal;
    logic [1:0] dec_imm_sel;

    control_decoder u_control_decoder (
        .i_opcode     (opcode),
        .i_funct      (funct),
        .o_alu_op     (dec_alu_op),
        .o_alu_src    (dec_alu_src),
        .o_mem_read   (dec_mem_read),
        .o_mem_write  (dec_mem_write),
        .o_reg_write  (dec_reg_write),
        .o_mem_to_reg (dec_mem_to_reg),
        .o_branch     (dec_branch),
        .o_branch_ne  (dec_branch_ne),
        .o_dst_rd     (dec_dst_rd),
        .o_uses_rt    (dec_uses_rt),
        .o_imm_sel    (dec_imm_sel),
        .o_illegal    (dec_illegal)
    );

    assign dest = dec_dst_rd ? rd : rt;

    always_comb begin
        dec_ctrl            = CTRL_NOP;
        dec_ctrl.alu_op     = dec_alu_op;
        dec_ctrl.alu_src    = dec_alu_src;
        dec_ctrl.mem_read   = dec_mem_read;
        dec_ctrl.mem_write  = dec_mem_write;
        dec_ctrl.reg_write  = dec_reg_write & (dest != '0);
        dec_ctrl.mem_to_reg = dec_mem_to_reg;
        dec_ctrl.branch     = dec_branch;
        dec_ctrl.branch_ne  = dec_branch_ne;
    end

    // Decoded payload; invalid or unsupported instructions become a bubble.
    always_comb begin
        dec = '0;
        if (i_valid && !dec_illegal) begin
            dec.valid   = 1'b1;
            dec.pc      = i_pc;
            dec.rs_data = (i_wb_en && (i_wb_addr != '0) && (i_wb_addr == rs)) ? i_wb_data : i_r1_data;
            dec.rt_data = (i_wb_en && (i_wb_addr != '0) && (i_wb_addr == rt)) ? i_wb_data : i_r2_data;
            dec.rs      = rs;
            dec.rt      = rt;
            dec.rd      = dest;
            dec.ctrl    = dec_ctrl;
            case (dec_imm_sel)
                IMM_ZEXT:  dec.imm = NB_DATA'(imm16);
                IMM_LUI:   dec.imm = NB_DATA'(imm16) << 16;
                IMM_SHAMT: dec.imm = NB_DATA'(shamt);
                default:   dec.imm = NB_DATA'($signed(imm16));
            endcase
        end
    end

    logic load_use;

    assign load_use = idex_q.valid && idex_q.ctrl.mem_read && (idex_q.rt != '0) && i_valid &&
                      ((idex_q.rt == rs) || (dec_uses_rt && (idex_q.rt == rt)));
    assign o_stall  = load_use && !i_flush;

    // Holding with i_en low clears the illegal flag so it stays a single pulse.
    always_comb begin
        idex_d    = idex_q;
        illegal_d = 1'b0;
        if (i_flush) begin
            idex_d = '0;
        end else if (!i_en) begin
            idex_d = idex_q;
        end else if (o_stall) begin
            idex_d = '0;
        end else begin
            idex_d    = dec;
            illegal_d = i_valid && dec_illegal;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            idex_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            idex_q    <= idex_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_illegal       = illegal_q;
    assign o_ex_valid      = idex_q.valid;
    assign o_ex_pc         = idex_q.pc;
    assign o_ex_rs_data    = idex_q.rs_data;
    assign o_ex_rt_data    = idex_q.rt_data;
    assign o_ex_imm        = idex_q.imm;
    assign o_ex_rs         = idex_q.rs;
    assign o_ex_rt         = idex_q.rt;
    assign o_ex_rd         = idex_q.rd;
    assign o_ex_alu_op     = idex_q.ctrl.alu_op;
    assign o_ex_alu_src    = idex_q.ctrl.alu_src;
    assign o_ex_mem_read   = idex_q.ctrl.mem_read;
    assign o_ex_mem_write  = idex_q.ctrl.mem_write;
    assign o_ex_reg_write  = idex_q.ctrl.reg_write;
    assign o_ex_mem_to_reg = idex_q.ctrl.mem_to_reg;
    assign o_ex_branch     = idex_q.ctrl.branch;
    assign o_ex_branch_ne  = idex_q.ctrl.branch_ne;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed expectations for decode,
// bypass, load-use stall, flush, illegal opcode, hold and async reset.
module tb_decode_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_en;
    logic        i_valid;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        i_wb_en;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic [4:0]  o_r1_addr, o_r2_addr;
    logic        o_r1_en, o_r2_en;
    logic [31:0] i_r1_data, i_r2_data;
    logic        o_stall, o_illegal, o_ex_valid;
    logic [31:0] o_ex_pc, o_ex_rs_data, o_ex_rt_data, o_ex_imm;
    logic [4:0]  o_ex_rs, o_ex_rt, o_ex_rd;
    logic [3:0]  o_ex_alu_op;
    logic        o_ex_alu_src, o_ex_mem_read, o_ex_mem_write, o_ex_reg_write;
    logic        o_ex_mem_to_reg, o_ex_branch, o_ex_branch_ne;

    int compared   = 0;
    int mismatched = 0;

    decode_stage #(.NB_DATA(32), .NB_ADDRESS(5), .NB_INSTR(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_valid(i_valid),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush),
        .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_r1_addr(o_r1_addr), .o_r2_addr(o_r2_addr), .o_r1_en(o_r1_en), .o_r2_en(o_r2_en),
        .i_r1_data(i_r1_data), .i_r2_data(i_r2_data),
        .o_stall(o_stall), .o_illegal(o_illegal), .o_ex_valid(o_ex_valid),
        .o_ex_pc(o_ex_pc), .o_ex_rs_data(o_ex_rs_data), .o_ex_rt_data(o_ex_rt_data),
        .o_ex_imm(o_ex_imm), .o_ex_rs(o_ex_rs), .o_ex_rt(o_ex_rt), .o_ex_rd(o_ex_rd),
        .o_ex_alu_op(o_ex_alu_op), .o_ex_alu_src(o_ex_alu_src),
        .o_ex_mem_read(o_ex_mem_read), .o_ex_mem_write(o_ex_mem_write),
        .o_ex_reg_write(o_ex_reg_write), .o_ex_mem_to_reg(o_ex_mem_to_reg),
        .o_ex_branch(o_ex_branch), .o_ex_branch_ne(o_ex_branch_ne)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        i_valid = 1'b1;
        i_instr = instr;
        i_pc    = pc;
    endtask

    initial begin
        i_reset = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_instr = '0; i_pc = '0;
        i_flush = 1'b0; i_wb_en = 1'b0; i_wb_addr = '0; i_wb_data = '0;
        i_r1_data = '0; i_r2_data = '0;

        // reset state
        #12;
        chk("rst_valid", 32'(o_ex_valid), 32'd0);
        chk("rst_illegal", 32'(o_illegal), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_regwrite", 32'(o_ex_reg_write), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;

        // ADDI r1,r0,-5
        drive(i_type(6'h08, 5'd0, 5'd1, 16'hFFFB), 32'h0000_0004);
        #1;
        chk("addi_r1addr", 32'(o_r1_addr), 32'd0);
        chk("addi_r2addr", 32'(o_r2_addr), 32'd1);
        chk("addi_r1en", 32'(o_r1_en), 32'd1);
        tick();
        chk("addi_valid", 32'(o_ex_valid), 32'd1);
        chk("addi_imm", o_ex_imm, 32'hFFFF_FFFB);
        chk("addi_alusrc", 32'(o_ex_alu_src), 32'd1);
        chk("addi_regwrite", 32'(o_ex_reg_write), 32'd1);
        chk("addi_rd", 32'(o_ex_rd), 32'd1);
        chk("addi_aluop", 32'(o_ex_alu_op), 32'd0);
        chk("addi_pc", o_ex_pc, 32'h0000_0004);

        // ORI r2,r0,0x8000 zero-extends
        drive(i_type(6'h0D, 5'd0, 5'd2, 16'h8000), 32'h0000_0008);
        tick();
        chk("ori_imm", o_ex_imm, 32'h0000_8000);
        chk("ori_aluop", 32'(o_ex_alu_op), 32'd3);
        chk("ori_rd", 32'(o_ex_rd), 32'd2);

        // LW r3,0(r0) then ADD r4,r3,r3: one-cycle stall
        drive(i_type(6'h23, 5'd0, 5'd3, 16'h0000), 32'h0000_000C);
        tick();
        chk("lw_memread", 32'(o_ex_mem_read), 32'd1);
        chk("lw_memtoreg", 32'(o_ex_mem_to_reg), 32'd1);
        chk("lw_rd", 32'(o_ex_rd), 32'd3);
        drive(r_type(5'd3, 5'd3, 5'd4, 5'd0, 6'h20), 32'h0000_0010);
        #1;
        chk("lu_stall_on", 32'(o_stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(o_ex_valid), 32'd0);
        chk("lu_bubble_memread", 32'(o_ex_mem_read), 32'd0);
        chk("lu_bubble_regwrite", 32'(o_ex_reg_write), 32'd0);
        chk("lu_stall_off", 32'(o_stall), 32'd0);
        tick();
        chk("lu_add_valid", 32'(o_ex_valid), 32'd1);
        chk("lu_add_rd", 32'(o_ex_rd), 32'd4);
        chk("lu_add_regwrite", 32'(o_ex_reg_write), 32'd1);
        chk("lu_add_alusrc", 32'(o_ex_alu_src), 32'd0);

        // Bypass: WB r5 while ADD r6,r5,r0 decodes
        i_wb_en = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hDEAD_BEEF;
        i_r1_data = 32'h1111_1111; i_r2_data = 32'h2222_2222;
        drive(r_type(5'd5, 5'd0, 5'd6, 5'd0, 6'h20), 32'h0000_0014);
        tick();
        chk("byp_rs_data", o_ex_rs_data, 32'hDEAD_BEEF);
        chk("byp_rt_data", o_ex_rt_data, 32'h2222_2222);
        // WB to r0 never bypasses
        i_wb_addr = 5'd0; i_wb_data = 32'hCAFE_F00D; i_r1_data = 32'h3333_3333;
        drive(r_type(5'd0, 5'd0, 5'd6, 5'd0, 6'h20), 32'h0000_0018);
        tick();
        chk("byp_r0_rs_data", o_ex_rs_data, 32'h3333_3333);
        chk("byp_r0_rt_data", o_ex_rt_data, 32'h2222_2222);
        i_wb_en = 1'b0;

        // Flush during load-use stall
        drive(i_type(6'h23, 5'd1, 5'd7, 16'h0004), 32'h0000_001C);
        tick();
        drive(r_type(5'd7, 5'd0, 5'd8, 5'd0, 6'h20), 32'h0000_0020);
        i_flush = 1'b1;
        #1;
        chk("fl_stall_masked", 32'(o_stall), 32'd0);
        tick();
        chk("fl_bubble_valid", 32'(o_ex_valid), 32'd0);
        chk("fl_bubble_memread", 32'(o_ex_mem_read), 32'd0);
        i_flush = 1'b0;
        #1;
        chk("fl_no_stall", 32'(o_stall), 32'd0);
        tick();
        chk("fl_add_valid", 32'(o_ex_valid), 32'd1);
        chk("fl_add_rd", 32'(o_ex_rd), 32'd8);

        // Illegal opcode 0x3F
        drive(i_type(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h0000_0024);
        tick();
        chk("ill_pulse", 32'(o_illegal), 32'd1);
        chk("ill_valid", 32'(o_ex_valid), 32'd0);
        chk("ill_regwrite", 32'(o_ex_reg_write), 32'd0);
        // SW r2,8(r1)
        drive(i_type(6'h2B, 5'd1, 5'd2, 16'h0008), 32'h0000_0028);
        tick();
        chk("ill_pulse_end", 32'(o_illegal), 32'd0);
        chk("sw_memwrite", 32'(o_ex_mem_write), 32'd1);
        chk("sw_regwrite", 32'(o_ex_reg_write), 32'd0);
        chk("sw_imm", o_ex_imm, 32'h0000_0008);
        chk("sw_rt", 32'(o_ex_rt), 32'd2);
        // Unsupported funct
        drive(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'h0000_002C);
        tick();
        chk("illfn_pulse", 32'(o_illegal), 32'd1);
        chk("illfn_valid", 32'(o_ex_valid), 32'd0);

        // ADDI r0,r1,1: destination r0 suppresses reg_write
        drive(i_type(6'h08, 5'd1, 5'd0, 16'h0001), 32'h0000_0030);
        tick();
        chk("r0dst_valid", 32'(o_ex_valid), 32'd1);
        chk("r0dst_regwrite", 32'(o_ex_reg_write), 32'd0);

        // SLL r9,r2,3
        drive(r_type(5'd0, 5'd2, 5'd9, 5'd3, 6'h00), 32'h0000_0034);
        tick();
        chk("sll_imm", o_ex_imm, 32'h0000_0003);
        chk("sll_aluop", 32'(o_ex_alu_op), 32'd7);
        chk("sll_rd", 32'(o_ex_rd), 32'd9);

        // LUI r10,0x1234
        drive(i_type(6'h0F, 5'd0, 5'd10, 16'h1234), 32'h0000_0038);
        tick();
        chk("lui_imm", o_ex_imm, 32'h1234_0000);
        chk("lui_aluop", 32'(o_ex_alu_op), 32'd10);

        // BNE r1,r2,-1
        drive(i_type(6'h05, 5'd1, 5'd2, 16'hFFFF), 32'h0000_003C);
        tick();
        chk("bne_branch_ne", 32'(o_ex_branch_ne), 32'd1);
        chk("bne_branch", 32'(o_ex_branch), 32'd0);
        chk("bne_aluop", 32'(o_ex_alu_op), 32'd1);
        chk("bne_imm", o_ex_imm, 32'hFFFF_FFFF);
        chk("bne_regwrite", 32'(o_ex_reg_write), 32'd0);

        // ANDI r11,r1,0xFFFF then hold with i_en=0
        drive(i_type(6'h0C, 5'd1, 5'd11, 16'hFFFF), 32'h0000_0040);
        tick();
        chk("andi_imm", o_ex_imm, 32'h0000_FFFF);
        i_en = 1'b0;
        drive(i_type(6'h08, 5'd0, 5'd12, 16'h0007), 32'h0000_0044);
        tick();
        chk("hold_rd", 32'(o_ex_rd), 32'd11);
        chk("hold_imm", o_ex_imm, 32'h0000_FFFF);
        chk("hold_pc", o_ex_pc, 32'h0000_0040);
        i_en = 1'b1;
        tick();
        chk("resume_rd", 32'(o_ex_rd), 32'd12);
        chk("resume_imm", o_ex_imm, 32'h0000_0007);

        // Asynchronous reset mid-stream
        i_reset = 1'b0;
        #1;
        chk("arst_valid", 32'(o_ex_valid), 32'd0);
        chk("arst_regwrite", 32'(o_ex_reg_write), 32'd0);
        chk("arst_imm", o_ex_imm, 32'd0);
        chk("arst_rd", 32'(o_ex_rd), 32'd0);
        chk("arst_alusrc", 32'(o_ex_alu_src), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        drive(i_type(6'h08, 5'd0, 5'd1, 16'hFFFB), 32'h0000_0004);
        tick();
        chk("post_rst_valid", 32'(o_ex_valid), 32'd1);
        chk("post_rst_imm", o_ex_imm, 32'hFFFF_FFFB);
        chk("post_rst_rd", 32'(o_ex_rd), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the pipelined MIPS core, sitting between the IF/ID latch and the execute stage. Splits the fetched instruction into fields, drives the read ports of `register_bank`, bypasses same-cycle write-back data, detects load-use hazards, and holds the ID/EX pipeline register that feeds execute.

## Interface
- `NB_DATA`, 32: datapath width.
- `NB_ADDRESS`, 5: register address width.
- `NB_INSTR`, 32: instruction width.
- `i_clk`  in  1  core clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-low reset (0 = reset).
- `i_en`  in  1  pipeline advance enable (debug step); 0 holds ID/EX.
- `i_valid`  in  1  IF/ID holds a valid instruction.
- `i_instr`  in  NB_INSTR  instruction from IF/ID.
- `i_pc`  in  NB_DATA  PC+4 of that instruction.
- `i_flush`  in  1  branch/jump taken in EX; squash the decoding instruction.
- `i_wb_en`, `i_wb_addr`, `i_wb_data`  in  1/NB_ADDRESS/NB_DATA  write-back port, shared with the register bank write port.
- `o_r1_addr`, `o_r2_addr`  out  NB_ADDRESS  rs/rt to the register bank.
- `o_r1_en`, `o_r2_en`  out  1  read enables; equal to `i_valid`.
- `i_r1_data`, `i_r2_data`  in  NB_DATA  register bank read data.
- `o_stall`  out  1  hold PC and IF/ID this cycle.
- `o_illegal`  out  1  one-cycle pulse: an unsupported opcode was decoded.
- `o_ex_valid`, `o_ex_pc`, `o_ex_rs_data`, `o_ex_rt_data`, `o_ex_imm`  out  1/NB_DATA×4  ID/EX payload.
- `o_ex_rs`, `o_ex_rt`, `o_ex_rd`  out  NB_ADDRESS  source and destination registers.
- `o_ex_alu_op`  out  4  ALU operation code.
- `o_ex_alu_src`, `o_ex_mem_read`, `o_ex_mem_write`, `o_ex_reg_write`, `o_ex_mem_to_reg`, `o_ex_branch`, `o_ex_branch_ne`  out  1  control bits.

## Operation
- Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]. `o_r1_addr`=rs and `o_r2_addr`=rt, both combinational.
- Supported instructions: R-type ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA; ADDI, SLTI, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE. Any other opcode or funct produces a bubble and asserts `o_illegal`.
- Destination: R-type uses rd; I-type uses rt. `reg_write` is forced to 0 when the destination is 0.
- Immediate: sign-extended, except zero-extended for ANDI/ORI/XORI. LUI produces imm<<16. Shifts place shamt in `o_ex_imm`[4:0].
- Bypass: if `i_wb_en` and `i_wb_addr`≠0 and `i_wb_addr` equals rs (or rt), use `i_wb_data` in place of `i_r1_data` (or `i_r2_data`).
- Load-use hazard (combinational): `o_stall`=1 when `o_ex_valid` & `o_ex_mem_read` & `o_ex_rt`≠0 & `i_valid` & (`o_ex_rt`==rs, or `o_ex_rt`==rt for R-type/SW/BEQ/BNE).
- ID/EX update priority, evaluated on each clock edge:
  1. Reset.
  2. `i_flush`: load a bubble.
  3. `!i_en`: hold.
  4. `o_stall`: load a bubble.
  5. Otherwise load the decoded instruction, with `o_ex_valid`=`i_valid`.
- Bubble: `o_ex_valid` and all control bits are 0. Data fields are don't-care but driven to 0.
- `o_stall` is forced to 0 while `i_flush`=1.

## Timing
- Latency: 1 cycle from `i_instr` to the ID/EX outputs.
- Reset: every `o_ex_*` output and `o_illegal` = 0 asynchronously. `o_stall`=0 because `o_ex_valid`=0.
- A load-use stall lasts exactly one cycle: the bubble clears `o_ex_mem_read`, which drops `o_stall`.
- Flush and stall in the same cycle: the flush wins and `o_stall`=0.
- Reset released mid-stream: the first edge after release loads normally.
- `o_illegal` is registered and aligned with the bubble it creates.

## Structure
- Package `decode_pkg`:
  - opcode and funct constants;
  - 4-bit ALU op encodings (ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA, LUI);
  - the bubble/NOP control vector.
- Sub-module `control_decoder`: purely combinational mapping from opcode/funct to the control bits and the illegal flag.
- The top level holds the bypass mux, hazard logic and the ID/EX register.

## Test plan
- ADDI r1,r0,-5 with `i_valid`=1 → next cycle `o_ex_imm`=0xFFFFFFFB, `alu_src`=1, `reg_write`=1, `o_ex_rd`=1.
- ORI r2,r0,0x8000 → `o_ex_imm`=0x00008000 (zero-extended).
- LW r3,0(r0) followed by ADD r4,r3,r3 → `o_stall`=1 for exactly one cycle, a bubble in ID/EX, then the ADD is issued.
- Write-back r5=0xDEADBEEF in the same cycle that ADD r6,r5,r0 is decoded → `o_ex_rs_data`=0xDEADBEEF. A write-back to r0 is not bypassed.
- `i_flush`=1 during a load-use stall → bubble loaded, `o_stall`=0.
- Opcode 0x3F → `o_illegal` pulse, `o_ex_valid`=0. `i_reset`=0 mid-stream → all outputs 0 immediately.
